ex_mul_div_unit: RTL and testbench



---
 rtl/mdu_pkg.sv | 23 ++
 rtl/ex_mul_div_unit_if.sv | 28 ++
 rtl/mdu_iter_core.sv | 54 +++++
 rtl/ex_mul_div_unit.sv | 154 +++++++++++++++
 tb/tb_ex_mul_div_unit.sv | 139 +++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// funct3 op codes, FSM state encoding and iteration counts.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // Iterations for the W (32-bit) variants; full width uses the top-level parameters.
  localparam int unsigned MDU_WORD_ITERS = 32;

endpackage

// File: rtl/ex_mul_div_unit_if.sv
// ID_EX-side request bundle and EX-side response of the multiply/divide unit.
// master = pipeline/controller side, slave = the unit.
interface ex_mul_div_unit_if #(
  parameter int unsigned XLEN = 64
);

  logic            valid_i;
  logic [2:0]      op_i;
  logic            word_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            hold_i;
  logic            kill_i;
  logic            stall_req_o;
  logic [XLEN-1:0] result_o;
  logic            result_valid_o;

  modport master (
    output valid_i, op_i, word_i, rs1_i, rs2_i, hold_i, kill_i,
    input  stall_req_o, result_o, result_valid_o
  );

  modport slave (
    input  valid_i, op_i, word_i, rs1_i, rs2_i, hold_i, kill_i,
    output stall_req_o, result_o, result_valid_o
  );

endinterface

// File: rtl/mdu_iter_core.sv
// Shared 2*XLEN accumulator/remainder register with one radix-2 step per cycle:
// shift-add multiply or restoring-subtract divide, chosen at load time.
module mdu_iter_core #(
  parameter int unsigned XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] init_i,
  input  logic [XLEN-1:0]   opd_i,
  output logic [2*XLEN-1:0] step_o
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opd_q;
  logic              div_q;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] mul_nxt;
  logic [2*XLEN-1:0] div_nxt;

  // Multiply: acc = {partial product, remaining multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff    = rem_sh - {1'b0, opd_q};
    if (!diff[XLEN]) begin
      div_nxt = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_nxt = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
    step_o = div_q ? div_nxt : mul_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      opd_q <= '0;
      div_q <= 1'b0;
    end else if (load_i) begin
      acc_q <= init_i;
      opd_q <= opd_i;
      div_q <= is_div_i;
    end else if (step_i) begin
      acc_q <= step_o;
    end
  end

endmodule

// File: rtl/ex_mul_div_unit.sv
// Iterative RV64M multiply/divide unit in EX: FSM, sign conditioning, special
// cases, final negation and the stall-request / hold / kill protocol.
module ex_mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned MUL_CYCLES = 64,
  parameter int unsigned DIV_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  ex_mul_div_unit_if.slave  mdu
);

  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam int unsigned WW    = MDU_WORD_ITERS;

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic             word_q;
  logic             neg_q;
  logic [XLEN-1:0]  result_q;

  logic              is_div, is_rem, sgn_a, sgn_b, sa, sb;
  logic              div_zero, div_ovf, special, start, neg_d;
  logic [XLEN-1:0]   a_ext, b_ext, mag_a, mag_b, dvd_res, spec_res, core_opd;
  logic [2*XLEN-1:0] init_acc;
  logic [CNT_W-1:0]  cnt_init;

  // Issue-side decode: operand extension, magnitudes, special cases, core preload.
  always_comb begin
    is_div = mdu.op_i[2];
    is_rem = mdu.op_i[2] & mdu.op_i[1];
    case (mdu.op_i)
      MDU_MULH, MDU_DIV, MDU_REM: {sgn_a, sgn_b} = 2'b11;
      MDU_MULHSU:                 {sgn_a, sgn_b} = 2'b10;
      default:                    {sgn_a, sgn_b} = 2'b00;
    endcase
    a_ext = mdu.word_i ? {{(XLEN-WW){sgn_a & mdu.rs1_i[WW-1]}}, mdu.rs1_i[WW-1:0]} : mdu.rs1_i;
    b_ext = mdu.word_i ? {{(XLEN-WW){sgn_b & mdu.rs2_i[WW-1]}}, mdu.rs2_i[WW-1:0]} : mdu.rs2_i;
    sa    = sgn_a & a_ext[XLEN-1];
    sb    = sgn_b & b_ext[XLEN-1];
    mag_a = sa ? -a_ext : a_ext;
    mag_b = sb ? -b_ext : b_ext;
    neg_d = is_rem ? sa : (sa ^ sb);

    dvd_res  = mdu.word_i ? {{(XLEN-WW){mdu.rs1_i[WW-1]}}, mdu.rs1_i[WW-1:0]} : mdu.rs1_i;
    div_zero = is_div & (b_ext == '0);
    div_ovf  = is_div & sgn_a & (b_ext == '1) &
               (a_ext == (mdu.word_i ? {{(XLEN-WW+1){1'b1}}, {(WW-1){1'b0}}}
                                     : {1'b1, {(XLEN-1){1'b0}}}));
    special  = div_zero | div_ovf;
    if (div_zero) begin
      spec_res = is_rem ? dvd_res : '1;
    end else begin
      spec_res = is_rem ? '0 : dvd_res;
    end

    // W divides start with the dividend at the top of the low half so 32 steps suffice.
    if (is_div) begin
      init_acc = mdu.word_i ? {{XLEN{1'b0}}, mag_a[WW-1:0], {(XLEN-WW){1'b0}}}
                            : {{XLEN{1'b0}}, mag_a};
      core_opd = mag_b;
    end else begin
      init_acc = {{XLEN{1'b0}}, mag_b};
      core_opd = mag_a;
    end
    cnt_init = mdu.word_i ? CNT_W'(WW) : (is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES));
    start    = (state_q == MDU_IDLE) & mdu.valid_i & ~mdu.kill_i;
  end

  logic [2*XLEN-1:0] acc_step, prod_s;
  logic [XLEN-1:0]   lo, hi, raw, fin;

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load_i   (start & ~special),
    .step_i   ((state_q == MDU_BUSY) & ~mdu.kill_i),
    .is_div_i (is_div),
    .init_i   (init_acc),
    .opd_i    (core_opd),
    .step_o   (acc_step)
  );

  // Result selection from the final step; a W multiply's product sits XLEN-32 bits up.
  always_comb begin
    lo     = acc_step[XLEN-1:0];
    hi     = acc_step[2*XLEN-1:XLEN];
    prod_s = neg_q ? -acc_step : acc_step;
    case (op_q)
      MDU_MUL:                         raw = word_q ? XLEN'(acc_step[(XLEN-WW) +: WW]) : lo;
      MDU_MULH, MDU_MULHSU, MDU_MULHU: raw = prod_s[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               raw = neg_q ? -lo : lo;
      MDU_REM, MDU_REMU:               raw = neg_q ? -hi : hi;
      default:                         raw = '0;
    endcase
    fin = word_q ? {{(XLEN-WW){raw[WW-1]}}, raw[WW-1:0]} : raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (mdu.kill_i) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (mdu.valid_i) begin
            op_q   <= mdu.op_i;
            word_q <= mdu.word_i;
            neg_q  <= neg_d;
            if (special) begin
              result_q <= spec_res;
              state_q  <= MDU_DONE;
            end else begin
              cnt_q   <= cnt_init;
              state_q <= MDU_BUSY;
            end
          end
        end
        MDU_BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_q <= fin;
            state_q  <= MDU_DONE;
          end
        end
        MDU_DONE: begin
          if (!mdu.hold_i) state_q <= MDU_IDLE;
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  // Stall request must rise in the issue cycle, so it is decoded from state and inputs.
  assign mdu.stall_req_o    = ~mdu.kill_i &
                              ((state_q == MDU_BUSY) | ((state_q == MDU_IDLE) & mdu.valid_i));
  assign mdu.result_valid_o = ~mdu.kill_i & (state_q == MDU_DONE);
  assign mdu.result_o       = result_q;

  valid_held_a: assert property (@(posedge clk) disable iff (rst)
    ((state_q == MDU_BUSY) && !mdu.kill_i) |-> mdu.valid_i);

endmodule

// File: tb/tb_ex_mul_div_unit.sv
// Directed bench for ex_mul_div_unit: scoreboard of expected results, stall
// counting, hold/kill/reset protocol checks.
module tb_ex_mul_div_unit;
  import mdu_pkg::*;

  localparam int unsigned XLEN  = 64;
  localparam int          LIMIT = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_mul_div_unit_if #(.XLEN(XLEN)) m ();

  ex_mul_div_unit #(.XLEN(XLEN), .MUL_CYCLES(64), .DIV_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (m)
  );

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] sb_q[$];

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " rv idle"}, XLEN'(m.result_valid_o), '0);
    chk({tag, " stall idle"}, XLEN'(m.stall_req_o), '0);
  endtask

  // Issue one op, count stall cycles until DONE, check result, optional hold, then retire.
  task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp, input int exp_stalls, input int hold_cycles);
    int stalls;
    int guard;
    logic [XLEN-1:0] want;
    stalls = 0;
    guard  = 0;
    sb_q.push_back(exp);
    m.valid_i = 1'b1; m.op_i = op; m.word_i = w; m.rs1_i = a; m.rs2_i = b;
    m.hold_i = 1'b0; m.kill_i = 1'b0;
    #1;
    while (m.result_valid_o !== 1'b1 && guard < LIMIT) begin
      if (m.stall_req_o === 1'b1) stalls++;
      @(posedge clk); #1;
      guard++;
    end
    chk({tag, " timeout"}, XLEN'(guard >= LIMIT), '0);
    chk({tag, " stalls"}, XLEN'(stalls), XLEN'(exp_stalls));
    chk({tag, " stall in done"}, XLEN'(m.stall_req_o), '0);
    want = sb_q.pop_front();
    chk({tag, " result"}, m.result_o, want);
    m.hold_i = (hold_cycles > 0);
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold rv"}, XLEN'(m.result_valid_o), XLEN'(1));
      chk({tag, " hold stall"}, XLEN'(m.stall_req_o), '0);
      chk({tag, " hold result"}, m.result_o, want);
    end
    m.hold_i = 1'b0;
    @(posedge clk); #1;
    m.valid_i = 1'b0;
    #1;
    chk_idle(tag);
  endtask

  initial begin
    rst = 1'b1;
    m.valid_i = 1'b0; m.op_i = '0; m.word_i = 1'b0; m.rs1_i = '0; m.rs2_i = '0;
    m.hold_i = 1'b0; m.kill_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset result", m.result_o, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("MUL",    MDU_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
    run_op("MULHU",  MDU_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
    run_op("MULHSU", MDU_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("MULW",   MDU_MUL,    1'b1, 64'h0000_0000_8000_0000, 64'd2, 64'd0, 33, 0);
    run_op("DIV",    MDU_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    run_op("REM hold", MDU_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65, 5);
    run_op("DIVU by0", MDU_DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("REMUW by0", MDU_REMU, 1'b1, 64'h5555_5555_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("DIV ovf", MDU_DIV,   1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1, 0);
    run_op("REM ovf", MDU_REM,   1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);

    // Kill at BUSY iteration 10.
    m.valid_i = 1'b1; m.op_i = MDU_DIV; m.word_i = 1'b0; m.rs1_i = 64'd1000; m.rs2_i = 64'd3;
    #1;
    chk("kill issue stall", XLEN'(m.stall_req_o), XLEN'(1));
    repeat (10) begin @(posedge clk); #1; end
    chk("kill busy stall", XLEN'(m.stall_req_o), XLEN'(1));
    m.kill_i = 1'b1;
    #1;
    chk("kill cycle stall", XLEN'(m.stall_req_o), '0);
    chk("kill cycle rv", XLEN'(m.result_valid_o), '0);
    @(posedge clk); #1;
    m.kill_i = 1'b0; m.valid_i = 1'b0;
    #1;
    chk_idle("after kill");
    run_op("DIVUW", MDU_DIVU, 1'b1, 64'hDEAD_0000_0000_0064, 64'd7, 64'd14, 33, 0);

    // Reset in the middle of a multiply.
    m.valid_i = 1'b1; m.op_i = MDU_MULHU; m.word_i = 1'b0; m.rs1_i = 64'd5; m.rs2_i = 64'd9;
    #1;
    repeat (20) begin @(posedge clk); #1; end
    chk("pre-reset stall", XLEN'(m.stall_req_o), XLEN'(1));
    rst = 1'b1; m.valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_idle("mid reset");
    chk("mid reset result", m.result_o, '0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("post reset rv", XLEN'(m.result_valid_o), '0);
    end

    run_op("REMW a", MDU_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
    run_op("REMW b", MDU_REM, 1'b1, 64'h1234_5678_0000_0064, 64'd7, 64'd2, 33, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
